// File: rtl/mem_store_buffer.sv
// Store buffer: circular FIFO of pending {addr, data} stores draining to data memory when loads are idle.
// Define STORE_BUFFER_FWD_EN for load forwarding; otherwise a matching load stalls and forces a drain.
module mem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [31:0]                st_addr_i,
  input  logic [31:0]                st_data_i,
  input  logic                       ld_valid_i,
  input  logic [31:0]                ld_addr_i,
  output logic [31:0]                ld_data_o,
  output logic                       ld_stall_o,
  output logic                       mem_write_enable_o,
  output logic [31:0]                mem_address_o,
  output logic [31:0]                mem_write_data_o,
  input  logic [31:0]                mem_read_data_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ent_addr_q [DEPTH];
  logic [31:0]   ent_addr_d [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [31:0]   ent_data_d [DEPTH];

  logic          full_s, push_s, drain_s, hit_s, ld_hit_s;
  logic [31:0]   hit_data_s;

  assign full_s = (count_q == FULL_CNT);
  assign push_s = st_valid_i && !full_s;

  // Scan oldest to youngest so the last hit wins (youngest matching store).
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [AW-1:0] idx;
      logic          hit_k;
      idx        = head_q + AW'(k);
      hit_k      = (CW'(k) < count_q) && (ent_addr_q[idx] == ld_addr_i);
      hit_data_s = hit_k ? ent_data_q[idx] : hit_data_s;
      hit_s      = hit_s | hit_k;
    end
  end

  assign ld_hit_s = ld_valid_i && hit_s;

`ifdef STORE_BUFFER_FWD_EN
  assign drain_s    = (count_q != '0) && (!ld_valid_i || full_s);
  assign ld_stall_o = ld_valid_i && full_s;
  assign ld_data_o  = ld_hit_s ? hit_data_s : mem_read_data_i;
`else
  assign drain_s    = (count_q != '0) && (!ld_valid_i || full_s || ld_hit_s);
  assign ld_stall_o = ld_valid_i && (full_s || ld_hit_s);
  assign ld_data_o  = mem_read_data_i;
`endif

  assign st_ready_o         = !full_s;
  assign count_o            = count_q;
  assign empty_o            = (count_q == '0);
  assign mem_write_enable_o = drain_s;
  assign mem_address_o      = drain_s ? ent_addr_q[head_q] : ld_addr_i;
  assign mem_write_data_o   = ent_data_q[head_q];

  // Next-state for pointers, occupancy and entry storage.
  always_comb begin
    head_d     = head_q + (drain_s ? AW'(1) : AW'(0));
    tail_d     = tail_q + (push_s ? AW'(1) : AW'(0));
    count_d    = count_q + CW'(push_s) - CW'(drain_s);
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    ent_addr_d[tail_q] = push_s ? st_addr_i : ent_addr_q[tail_q];
    ent_data_d[tail_q] = push_s ? st_data_i : ent_data_q[tail_q];
  end

  // Valid state only; reset discards every pending store.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed scenarios then random traffic against a queue model.
module tb_mem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = 32'd0;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [$clog2(DEPTH):0] count;
  logic        empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit   [31:0] ref_mem  [256];
  bit   [31:0] phys_mem [256];
  logic [31:0] pool [4];

  mem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .st_valid_i(st_valid), .st_ready_o(st_ready),
    .st_addr_i(st_addr), .st_data_i(st_data),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr),
    .ld_data_o(ld_data), .ld_stall_o(ld_stall),
    .mem_write_enable_o(mem_we), .mem_address_o(mem_addr),
    .mem_write_data_o(mem_wdata), .mem_read_data_i(mem_rdata),
    .count_o(count), .empty_o(empty)
  );

  always #5 clk = ~clk;

  assign mem_rdata = phys_mem[mem_addr[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) phys_mem[i] = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_we) phys_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, predict from the queue model, compare, then advance the model.
  task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    int          n;
    logic        full, hit, drain, stall, fwd;
    logic [31:0] yd, exp_ld;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
    #1;
    n    = q.size();
    full = (n == DEPTH);
    hit  = 1'b0;
    yd   = 32'd0;
    if (lv) begin
      foreach (q[i]) begin
        if (q[i].a == la) begin
          hit = 1'b1;
          yd  = q[i].d;
        end
      end
    end
`ifdef STORE_BUFFER_FWD_EN
    fwd   = 1'b1;
    drain = (n > 0) && (!lv || full);
    stall = lv && full;
`else
    fwd   = 1'b0;
    drain = (n > 0) && (!lv || full || hit);
    stall = lv && (full || hit);
`endif
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("st_ready", 32'(st_ready), 32'(!full));
    chk("mem_we", 32'(mem_we), 32'(drain));
    if (drain) begin
      chk("mem_addr_drain", mem_addr, q[0].a);
      chk("mem_wdata", mem_wdata, q[0].d);
    end else begin
      chk("mem_addr_load", mem_addr, la);
    end
    chk("ld_stall", 32'(ld_stall), 32'(stall));
    if (lv && !stall) begin
      exp_ld = (fwd && hit) ? yd : ref_mem[la[7:0]];
      chk("ld_data", ld_data, exp_ld);
    end
    @(posedge clk);
    if (drain) begin
      ref_mem[q[0].a[7:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (sv && !full) q.push_back('{sa, sd});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    st_valid = 1'b0;
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0300;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_stall", 32'(ld_stall), 32'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    pool[0] = 32'h0000_0020;
    pool[1] = 32'h8000_0020;
    pool[2] = 32'h0000_0024;
    pool[3] = 32'h0001_0024;

    @(negedge clk);
    do_reset();

    // Single store reaches memory the cycle after its push.
    cycle(1'b1, 32'h10, 32'hAAAA_0001, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Loads held busy: fill to DEPTH, then full-stall forces drains.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'h40 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1'b1, 32'h100);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Same address stored twice, then loaded.
    cycle(1'b1, 32'h20, 32'd1, 1'b1, 32'h200);
    cycle(1'b1, 32'h20, 32'd2, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    cycle(1'b1, 32'h20, 32'd5, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    // Upper-bit alias must not match.
    cycle(1'b1, 32'h8000_0020, 32'd7, 1'b1, 32'h300);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Nine stores under continuous drain, pointers wrap.
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 32'h80 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 32'h0);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Reset with three pending stores discards them.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'hA0 + 32'(i * 4), 32'hDEAD_0000 + 32'(i), 1'b1, 32'h300);
    chk("pre_rst_count", 32'(count), 32'd3);
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Random traffic over a small aliasing address pool.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            pool[$urandom_range(0, 3)], $urandom,
            ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
            pool[$urandom_range(0, 3)]);
    end
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
